// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned MEM_DEPTH = 100;
  localparam int unsigned MAX_BURST = 16;
  localparam int unsigned BEAT_W    = 4;
  localparam int unsigned LEN_W     = 5;

  typedef enum logic {
    ST_IDLE,
    ST_DMA
  } state_t;

  typedef enum logic {
    WIN_CPU,
    WIN_DMA
  } winner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, DMA and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  // CPU load/store port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_err;

  // DMA loader port
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [LEN_W-1:0]  dma_len;
  logic [DATA_W-1:0] dma_wdata;
  logic [BEAT_W-1:0] dma_beat;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic              dma_done;
  logic              dma_err;

  // data_memory strobes
  logic              mem_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_add;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid, cpu_err,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_beat, dma_gnt, dma_rdata, dma_rvalid, dma_done, dma_err,
    output mem_rd, mem_we, mem_add, mem_data_in,
    input  mem_data_out
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid, cpu_err,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_beat, dma_gnt, dma_rdata, dma_rvalid, dma_done, dma_err,
    input  mem_rd, mem_we, mem_add, mem_data_in,
    output mem_data_out
  );

endinterface

// File: rtl/dmem_arbiter_burst_ctr.sv
// Burst bookkeeping: latched base/length, beat index, beat address, last flag.
module dmem_burst_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic              clr,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [BEAT_W-1:0] beat,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;

  // Beat 0 is issued in the acceptance cycle, so a load leaves the index at 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q <= '0;
      len_q  <= '0;
      beat   <= '0;
    end else if (clr) begin
      beat <= '0;
    end else if (load) begin
      base_q <= base_in;
      len_q  <= len_in;
      beat   <= BEAT_W'(1);
    end else if (adv) begin
      beat <= beat + BEAT_W'(1);
    end
  end

  assign addr = base_q + ADDR_W'(beat);
  assign last = (LEN_W'(beat) == (len_q - LEN_W'(1)));

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing data_memory between the CPU and a burst DMA.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = dmem_arb_pkg::MEM_DEPTH,
  parameter int unsigned MAX_BURST = dmem_arb_pkg::MAX_BURST
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
  localparam logic [LEN_W-1:0]  MAXB_L  = LEN_W'(MAX_BURST);

  state_t            state;
  winner_t           last_win;
  logic              dma_we_q;

  logic              in_idle;
  logic              cpu_win;
  logic              dma_win;
  logic              cpu_oob;
  logic              cpu_access;
  logic              len_bad;
  logic [ADDR_W-1:0] dma_cur_addr;
  logic              dma_cur_we;
  logic              dma_oob;
  logic              dma_last;
  logic              dma_access;
  logic              dma_end;
  logic              ctr_load;
  logic              ctr_adv;
  logic              ctr_clr;
  logic [ADDR_W-1:0] ctr_addr;
  logic              ctr_last;

  assign in_idle = (state == ST_IDLE);

  // Winner of this cycle; inside a burst the CPU takes every cycle after a DMA beat.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (rst) begin
      if (in_idle) begin
        cpu_win = bus.cpu_req && (!bus.dma_req || (last_win == WIN_DMA));
        dma_win = bus.dma_req && !cpu_win;
      end else begin
        cpu_win = bus.cpu_req && (last_win == WIN_DMA);
        dma_win = !cpu_win;
      end
    end
  end

  assign cpu_oob    = (bus.cpu_addr >= DEPTH_A);
  assign cpu_access = cpu_win && !cpu_oob;

  // In IDLE the beat-0 parameters come straight from the request.
  assign len_bad      = in_idle && ((bus.dma_len == '0) || (bus.dma_len > MAXB_L));
  assign dma_cur_addr = in_idle ? bus.dma_addr : ctr_addr;
  assign dma_cur_we   = in_idle ? bus.dma_we : dma_we_q;
  assign dma_last     = in_idle ? (bus.dma_len == LEN_W'(1)) : ctr_last;
  assign dma_oob      = (dma_cur_addr >= DEPTH_A);
  assign dma_access   = dma_win && !len_bad && !dma_oob;
  assign dma_end      = dma_win && (len_bad || dma_oob || dma_last);

  assign ctr_load = in_idle && dma_win && !dma_end;
  assign ctr_adv  = !in_idle && dma_win && !dma_end;
  assign ctr_clr  = !in_idle && dma_end;

  dmem_burst_ctr #(
    .ADDR_W (ADDR_W)
  ) u_burst_ctr (
    .clk     (clk),
    .rst     (rst),
    .load    (ctr_load),
    .adv     (ctr_adv),
    .clr     (ctr_clr),
    .base_in (bus.dma_addr),
    .len_in  (bus.dma_len),
    .beat    (bus.dma_beat),
    .addr    (ctr_addr),
    .last    (ctr_last)
  );

  assign bus.cpu_gnt     = cpu_win;
  assign bus.dma_gnt     = dma_win;
  assign bus.mem_rd      = (cpu_access && !bus.cpu_we) || (dma_access && !dma_cur_we);
  assign bus.mem_we      = (cpu_access && bus.cpu_we) || (dma_access && dma_cur_we);
  assign bus.mem_add     = cpu_access ? bus.cpu_addr : (dma_access ? dma_cur_addr : '0);
  assign bus.mem_data_in = cpu_access ? bus.cpu_wdata :
                           (dma_access ? bus.dma_wdata : {DATA_W{1'b0}});

  // FSM, round-robin history and registered responses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      last_win       <= WIN_DMA;
      dma_we_q       <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.cpu_rvalid <= 1'b0;
      bus.cpu_err    <= 1'b0;
      bus.dma_rdata  <= '0;
      bus.dma_rvalid <= 1'b0;
      bus.dma_done   <= 1'b0;
      bus.dma_err    <= 1'b0;
    end else begin
      bus.cpu_rvalid <= cpu_win;
      bus.cpu_err    <= cpu_win && cpu_oob;
      if (cpu_access && !bus.cpu_we) bus.cpu_rdata <= bus.mem_data_out;

      bus.dma_rvalid <= dma_access && !dma_cur_we;
      if (dma_access && !dma_cur_we) bus.dma_rdata <= bus.mem_data_out;
      bus.dma_done   <= dma_end;
      bus.dma_err    <= dma_win && (len_bad || dma_oob);

      if (cpu_win)      last_win <= WIN_CPU;
      else if (dma_win) last_win <= WIN_DMA;

      case (state)
        ST_IDLE: if (dma_win && !dma_end) begin
          state    <= ST_DMA;
          dma_we_q <= bus.dma_we;
        end
        ST_DMA: if (dma_end) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small data_memory model.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

  dmem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_DEPTH (100),
    .MAX_BURST (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: unwritten words read as 0x5000 + address.
  logic [31:0] mem     [0:127];
  bit          written [0:127];
  logic [6:0]  ma;
  assign ma = ifc.mem_add[6:0];

  always @(posedge clk) begin
    if (ifc.mem_we && (ifc.mem_add < 32'd128)) begin
      mem[ma]     <= ifc.mem_data_in;
      written[ma] <= 1'b1;
    end
  end

  assign ifc.mem_data_out = (ifc.mem_rd && (ifc.mem_add < 32'd128)) ?
                            (written[ma] ? mem[ma] : 32'h5000 + ifc.mem_add) : 32'h0;

  // DMA write data tracks the beat index.
  assign ifc.dma_wdata = 32'h100 + 32'(ifc.dma_beat);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    ifc.cpu_req   = 1'b0;
    ifc.cpu_we    = 1'b0;
    ifc.cpu_addr  = '0;
    ifc.cpu_wdata = '0;
    ifc.dma_req   = 1'b0;
    ifc.dma_we    = 1'b0;
    ifc.dma_addr  = '0;
    ifc.dma_len   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    next();
    rst = 1'b1;
  endtask

  task automatic cpu_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    ifc.cpu_req   = 1'b1;
    ifc.cpu_we    = we;
    ifc.cpu_addr  = addr;
    ifc.cpu_wdata = wdata;
  endtask

  task automatic dma_drive(input logic we, input logic [31:0] addr, input logic [4:0] len);
    ifc.dma_req  = 1'b1;
    ifc.dma_we   = we;
    ifc.dma_addr = addr;
    ifc.dma_len  = len;
  endtask

  int   quiet_done;
  logic [4:0] bad_len [2];

  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();
    rst = 1'b0;

    // Reset: strobes low even with a request pending
    cpu_drive(1'b0, 32'd5, 32'h0);
    next();
    next();
    settle();
    check("rst_cpu_gnt", 32'(ifc.cpu_gnt), 32'd0);
    check("rst_mem_rd", 32'(ifc.mem_rd), 32'd0);
    check("rst_cpu_rvalid", 32'(ifc.cpu_rvalid), 32'd0);
    check("rst_dma_done", 32'(ifc.dma_done), 32'd0);
    idle_inputs();
    rst = 1'b1;
    next();
    settle();
    check("post_rst_cpu_rvalid", 32'(ifc.cpu_rvalid), 32'd0);
    check("post_rst_cpu_rdata", ifc.cpu_rdata, 32'd0);
    check("post_rst_dma_beat", 32'(ifc.dma_beat), 32'd0);
    next();

    // CPU write 0xAA to 50, then read 50 back-to-back
    cpu_drive(1'b1, 32'd50, 32'hAA);
    settle();
    check("wr_cpu_gnt", 32'(ifc.cpu_gnt), 32'd1);
    check("wr_mem_we", 32'(ifc.mem_we), 32'd1);
    check("wr_mem_rd", 32'(ifc.mem_rd), 32'd0);
    check("wr_mem_add", ifc.mem_add, 32'd50);
    check("wr_mem_data_in", ifc.mem_data_in, 32'hAA);
    next();
    cpu_drive(1'b0, 32'd50, 32'h0);
    settle();
    check("rd_cpu_gnt", 32'(ifc.cpu_gnt), 32'd1);
    check("rd_mem_rd", 32'(ifc.mem_rd), 32'd1);
    check("wr_ack_rvalid", 32'(ifc.cpu_rvalid), 32'd1);
    check("wr_ack_err", 32'(ifc.cpu_err), 32'd0);
    check("wr_ack_rdata_hold", ifc.cpu_rdata, 32'd0);
    next();
    idle_inputs();
    settle();
    check("rd_rvalid", 32'(ifc.cpu_rvalid), 32'd1);
    check("rd_rdata", ifc.cpu_rdata, 32'hAA);
    next();

    // Simultaneous CPU + DMA after reset: CPU first, then alternate
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cpu_drive(1'b0, 32'(10 + i), 32'h0);
      if (i < 2) dma_drive(1'b1, 32'd20, 5'd4);
      else ifc.dma_req = 1'b0;
      settle();
      check($sformatf("alt_cpu_gnt_%0d", i), 32'(ifc.cpu_gnt), 32'((i % 2) == 0));
      check($sformatf("alt_dma_gnt_%0d", i), 32'(ifc.dma_gnt), 32'((i % 2) == 1));
      if ((i % 2) == 1) begin
        check($sformatf("alt_beat_%0d", i), 32'(ifc.dma_beat), 32'(i / 2));
        check($sformatf("alt_dma_add_%0d", i), ifc.mem_add, 32'(20 + i / 2));
        check($sformatf("alt_dma_we_%0d", i), 32'(ifc.mem_we), 32'd1);
        check($sformatf("alt_dma_wd_%0d", i), ifc.mem_data_in, 32'(32'h100 + i / 2));
        check($sformatf("alt_cpu_rdata_%0d", i), ifc.cpu_rdata, 32'(32'h5000 + 10 + i - 1));
      end else begin
        check($sformatf("alt_cpu_add_%0d", i), ifc.mem_add, 32'(10 + i));
      end
      next();
    end
    idle_inputs();
    settle();
    check("alt_dma_done", 32'(ifc.dma_done), 32'd1);
    check("alt_dma_err", 32'(ifc.dma_err), 32'd0);
    next();
    settle();
    check("alt_done_pulse", 32'(ifc.dma_done), 32'd0);
    next();

    // DMA write base 96 len 8: beats 0..3 written, beat 4 (addr 100) aborts
    for (int i = 0; i < 5; i++) begin
      if (i == 0) dma_drive(1'b1, 32'd96, 5'd8);
      else ifc.dma_req = 1'b0;
      settle();
      if (i < 4) begin
        check($sformatf("oob_we_%0d", i), 32'(ifc.mem_we), 32'd1);
        check($sformatf("oob_add_%0d", i), ifc.mem_add, 32'(96 + i));
        check($sformatf("oob_beat_%0d", i), 32'(ifc.dma_beat), 32'(i));
      end else begin
        check("oob_beat4_we", 32'(ifc.mem_we), 32'd0);
        check("oob_beat4_rd", 32'(ifc.mem_rd), 32'd0);
      end
      next();
    end
    cpu_drive(1'b0, 32'd97, 32'h0);
    settle();
    check("oob_done", 32'(ifc.dma_done), 32'd1);
    check("oob_err", 32'(ifc.dma_err), 32'd1);
    next();
    idle_inputs();
    settle();
    check("oob_done_pulse", 32'(ifc.dma_done), 32'd0);
    check("burst_wr_data", ifc.cpu_rdata, 32'h101);
    next();

    // CPU read out of range
    cpu_drive(1'b0, 32'd120, 32'h0);
    settle();
    check("cpu_oob_gnt", 32'(ifc.cpu_gnt), 32'd1);
    check("cpu_oob_rd", 32'(ifc.mem_rd), 32'd0);
    next();
    idle_inputs();
    settle();
    check("cpu_oob_rvalid", 32'(ifc.cpu_rvalid), 32'd1);
    check("cpu_oob_err", 32'(ifc.cpu_err), 32'd1);
    check("cpu_oob_rdata_hold", ifc.cpu_rdata, 32'h101);
    next();

    // Invalid burst lengths
    bad_len[0] = 5'd0;
    bad_len[1] = 5'd17;
    for (int k = 0; k < 2; k++) begin
      dma_drive(1'b0, 32'd4, bad_len[k]);
      settle();
      check($sformatf("len%0d_rd", bad_len[k]), 32'(ifc.mem_rd), 32'd0);
      check($sformatf("len%0d_we", bad_len[k]), 32'(ifc.mem_we), 32'd0);
      next();
      idle_inputs();
      settle();
      check($sformatf("len%0d_done", bad_len[k]), 32'(ifc.dma_done), 32'd1);
      check($sformatf("len%0d_err", bad_len[k]), 32'(ifc.dma_err), 32'd1);
      next();
    end

    // Reset during beat 5 of a 16-beat read burst
    for (int i = 0; i < 6; i++) begin
      if (i == 0) dma_drive(1'b0, 32'd0, 5'd16);
      else ifc.dma_req = 1'b0;
      settle();
      check($sformatf("mid_beat_%0d", i), 32'(ifc.dma_beat), 32'(i));
      if (i == 5) rst = 1'b0;
      next();
    end
    rst = 1'b1;
    settle();
    check("mid_rst_gnt", 32'(ifc.dma_gnt), 32'd0);
    check("mid_rst_rvalid", 32'(ifc.dma_rvalid), 32'd0);
    check("mid_rst_done", 32'(ifc.dma_done), 32'd0);
    check("mid_rst_beat", 32'(ifc.dma_beat), 32'd0);
    check("mid_rst_rd", 32'(ifc.mem_rd), 32'd0);
    quiet_done = 0;
    for (int i = 0; i < 3; i++) begin
      next();
      settle();
      if (ifc.dma_done) quiet_done++;
    end
    check("mid_rst_no_done", 32'(quiet_done), 32'd0);
    next();

    dma_drive(1'b0, 32'd40, 5'd2);
    settle();
    check("new_gnt0", 32'(ifc.dma_gnt), 32'd1);
    check("new_add0", ifc.mem_add, 32'd40);
    check("new_rd0", 32'(ifc.mem_rd), 32'd1);
    next();
    idle_inputs();
    settle();
    check("new_beat1", 32'(ifc.dma_beat), 32'd1);
    check("new_add1", ifc.mem_add, 32'd41);
    check("new_rvalid0", 32'(ifc.dma_rvalid), 32'd1);
    check("new_rdata0", ifc.dma_rdata, 32'h5028);
    next();
    settle();
    check("new_done", 32'(ifc.dma_done), 32'd1);
    check("new_err", 32'(ifc.dma_err), 32'd0);
    check("new_rvalid1", 32'(ifc.dma_rvalid), 32'd1);
    check("new_rdata1", ifc.dma_rdata, 32'h5029);
    next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
